// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data) arbiter in front of a single-port SRAM.
// Data wins by default; a starvation counter forces an instruction grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic        iGnt,
  output logic        dGnt,
  output logic        iDone,
  output logic        dDone,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        memEn,
  output logic        memWe,
  output logic [13:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t      state;
  state_t      state_nxt;
  owner_t      owner;
  logic [3:0]  cnt;
  logic [3:0]  starve;
  logic [13:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        pick_d;

  // The SRAM is word addressed and only 16K words deep; the remaining address bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iAddr[31:16], iAddr[1:0], dAddr[31:16], dAddr[1:0]};

  // NOTE: every output and next-state variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    iGnt      = 1'b0;
    dGnt      = 1'b0;
    iDone     = 1'b0;
    dDone     = 1'b0;
    busy      = 1'b0;
    memEn     = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWdata  = '0;
    pick_d    = dReq && !(iReq && (starve == 4'(STARVE_MAX)));
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (iReq || dReq) begin
            dGnt      = pick_d;
            iGnt      = !pick_d;
            state_nxt = ACCESS;
          end
        end
        ACCESS: begin
          busy     = 1'b1;
          memEn    = 1'b1;
          memWe    = we_q;
          memAddr  = addr_q;
          memWdata = wdata_q;
          if (cnt == 4'd0) state_nxt = RESP;
        end
        RESP: begin
          busy      = 1'b1;
          iDone     = (owner == OWN_I);
          dDone     = (owner == OWN_D);
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      starve  <= '0;
      owner   <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (dGnt) begin
            cnt     <= 4'(LATENCY - 1);
            owner   <= OWN_D;
            addr_q  <= dAddr[15:2];
            we_q    <= dWe;
            wdata_q <= dWdata;
            if (!iReq)                          starve <= '0;
            else if (starve != 4'(STARVE_MAX))  starve <= starve + 4'd1;
          end else if (iGnt) begin
            cnt     <= 4'(LATENCY - 1);
            owner   <= OWN_I;
            addr_q  <= iAddr[15:2];
            we_q    <= 1'b0;
            wdata_q <= '0;
            starve  <= '0;
          end
        end
        ACCESS: begin
          // Capture happens for stores too, so rdata always reflects the last completed access.
          if (cnt == 4'd0) rdata_q <= memRdata;
          else             cnt     <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed timing checks plus a grant/done scoreboard
// backed by a reference copy of the SRAM contents and an independent starvation model.
module tb_mem_arbiter;
  localparam int LATENCY    = 2;
  localparam int STARVE_MAX = 2;

  logic        clk;
  logic        reset;
  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWdata;
  logic        iGnt, dGnt, iDone, dDone, busy, memEn, memWe;
  logic [31:0] rdata, memWdata, memRdata;
  logic [13:0] memAddr;

  typedef struct {
    bit          is_d;
    bit          is_load;
    logic [31:0] data;
  } resp_t;

  resp_t      resp_q[$];
  bit         gnt_log[$];
  int         starve_m;
  int         n_checks;
  int         n_errors;
  bit [31:0]  sram[16384];
  bit         sram_v[16384];
  bit [31:0]  ref_mem[16384];
  bit         ref_v[16384];

  mem_arbiter #(.LATENCY(LATENCY), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .iGnt(iGnt), .dGnt(dGnt), .iDone(iDone), .dDone(dDone),
    .rdata(rdata), .busy(busy),
    .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [13:0] a);
    return 32'hA500_0000 | {18'd0, a};
  endfunction

  // SRAM model: asynchronous read, synchronous write.
  always_comb memRdata = sram_v[memAddr] ? sram[memAddr] : init_val(memAddr);
  always @(posedge clk) begin
    if (memEn && memWe) begin
      sram[memAddr]   <= memWdata;
      sram_v[memAddr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [13:0] a);
    return ref_v[a] ? ref_mem[a] : init_val(a);
  endfunction

  // Scoreboard step, run once per cycle at the falling edge.
  task automatic observe();
    resp_t e;
    bit    exp_d;
    if (reset) begin
      resp_q.delete();
      starve_m = 0;
      return;
    end
    check("gnt_excl", 32'(iGnt & dGnt), 32'd0);
    if (iGnt || dGnt) begin
      exp_d = dReq && !(iReq && starve_m == STARVE_MAX);
      check("gnt_pick", 32'(dGnt), 32'(exp_d));
      gnt_log.push_back(dGnt);
      if (dGnt) begin
        e.is_d    = 1'b1;
        e.is_load = !dWe;
        e.data    = ref_read(dAddr[15:2]);
        if (dWe) begin
          ref_mem[dAddr[15:2]] = dWdata;
          ref_v[dAddr[15:2]]   = 1'b1;
        end
        if (!iReq)                    starve_m = 0;
        else if (starve_m < STARVE_MAX) starve_m++;
      end else begin
        e.is_d    = 1'b0;
        e.is_load = 1'b1;
        e.data    = ref_read(iAddr[15:2]);
        starve_m  = 0;
      end
      resp_q.push_back(e);
    end
    if (iDone || dDone) begin
      check("done_pending", 32'(resp_q.size() > 0), 32'd1);
      if (resp_q.size() > 0) begin
        e = resp_q.pop_front();
        check("done_owner", 32'(dDone), 32'(e.is_d));
        if (e.is_load) check("sb_rdata", rdata, e.data);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    observe();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      next();
      look();
      n++;
    end while (!(iDone || dDone) && n < 20);
    check(tag, 32'(iDone | dDone), 32'd1);
  endtask

  initial begin
    bit exp_order[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int n;
    n_checks = 0;
    n_errors = 0;
    starve_m = 0;
    reset = 1'b1; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dWdata = '0;

    // Reset: requests present but nothing may be granted or driven.
    next(); iReq = 1'b1; dReq = 1'b1; look();
    check("rst_ignt", 32'(iGnt), 32'd0);
    check("rst_dgnt", 32'(dGnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memen", 32'(memEn | memWe), 32'd0);
    check("rst_memaddr", 32'(memAddr), 32'd0);
    check("rst_memwdata", memWdata, 32'd0);
    next(); reset = 1'b0; iReq = 1'b0; dReq = 1'b0; look();
    check("rst_rdata", rdata, 32'd0);
    check("idle_memen", 32'(memEn), 32'd0);

    // Single instruction fetch timing.
    next(); iReq = 1'b1; iAddr = 32'h0040_0008; look();
    check("t1_ignt", 32'(iGnt), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      next(); look();
      check("t1_memen", 32'(memEn), 32'd1);
      check("t1_memaddr", 32'(memAddr), 32'h0002);
      check("t1_busy", 32'(busy), 32'd1);
    end
    next(); look();
    check("t1_idone", 32'(iDone), 32'd1);
    check("t1_rdata", rdata, 32'hA500_0002);
    next(); iReq = 1'b0; look();
    check("t1_busy_low", 32'(busy), 32'd0);

    // Simultaneous requests: data first, instruction right after.
    next(); iReq = 1'b1; iAddr = 32'h0000_0100; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h10; look();
    check("t2_dgnt", 32'(dGnt), 32'd1);
    next(); look(); next(); look(); next(); look();
    check("t2_ddone", 32'(dDone), 32'd1);
    check("t2_drdata", rdata, 32'hA500_0004);
    next(); dReq = 1'b0; look();
    check("t2_ignt", 32'(iGnt), 32'd1);
    next(); look(); next(); look(); next(); look();
    check("t2_idone", 32'(iDone), 32'd1);
    check("t2_irdata", rdata, 32'hA500_0040);
    next(); iReq = 1'b0; look();

    // Store then back-to-back load of the same word (request kept high after done).
    next(); dReq = 1'b1; dWe = 1'b1; dAddr = 32'h54; dWdata = 32'h0000_0007; look();
    check("t3_dgnt", 32'(dGnt), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      next(); look();
      check("t3_memwe", 32'(memWe), 32'd1);
      check("t3_memaddr", 32'(memAddr), 32'h0015);
      check("t3_memwdata", memWdata, 32'd7);
    end
    next(); look();
    check("t3_ddone", 32'(dDone), 32'd1);
    next(); dWe = 1'b0; look();
    check("t3_dgnt2", 32'(dGnt), 32'd1);
    next(); look(); next(); look(); next(); look();
    check("t3_ddone2", 32'(dDone), 32'd1);
    check("t3_load", rdata, 32'h0000_0007);
    next(); dReq = 1'b0; look();

    // Starvation: both requests held high continuously.
    gnt_log.delete();
    next(); iReq = 1'b1; iAddr = 32'h200; dReq = 1'b1; dAddr = 32'h300; look();
    n = 0;
    while (gnt_log.size() < 6 && n < 60) begin
      next(); look(); n++;
    end
    check("t4_ngrants", 32'(gnt_log.size()), 32'd6);
    for (int k = 0; k < 6 && k < gnt_log.size(); k++)
      check($sformatf("t4_order%0d", k), 32'(gnt_log[k]), 32'(exp_order[k]));
    wait_done("t4_last_done");
    next(); iReq = 1'b0; dReq = 1'b0; look();

    // Reset in the first ACCESS cycle of the second data transfer (starvation count at max).
    next(); iReq = 1'b1; dReq = 1'b1; look();
    check("t5_dgnt1", 32'(dGnt), 32'd1);
    next(); look(); next(); look(); next(); look();
    next(); look();
    check("t5_dgnt2", 32'(dGnt), 32'd1);
    next(); reset = 1'b1; look();
    check("t5_rst_memen", 32'(memEn), 32'd0);
    next(); reset = 1'b0; iReq = 1'b0; dReq = 1'b0; look();
    check("t5_memen", 32'(memEn), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 6; c++) begin
      next(); look();
      check("t5_no_done", 32'(iDone | dDone), 32'd0);
    end
    next(); iReq = 1'b1; dReq = 1'b1; look();
    check("t5_starve_clr", 32'(dGnt), 32'd1);
    wait_done("t5_done");
    next(); iReq = 1'b0; dReq = 1'b0; look();
    check("t5_sb_empty", 32'(resp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, 2, memory access cycles per transfer (legal 1..8).
REQ-002 Parameter: STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits (legal 1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 iReq  input  1  instruction-fetch request, level, held until iDone.
REQ-006 iAddr  input  32  instruction byte address, stable while iReq high.
REQ-007 dReq  input  1  data request, level, held until dDone.
REQ-008 dWe  input  1  data request is a store when 1.
REQ-009 dAddr  input  32  data byte address, stable while dReq high.
REQ-010 dWdata  input  32  store data, stable while dReq high.
REQ-011 iGnt, dGnt  output  1 each  one-cycle accept pulse.
REQ-012 iDone, dDone  output  1 each  one-cycle completion pulse.
REQ-013 rdata  output  32  registered read data, valid during iDone/dDone.
REQ-014 busy  output  1  high in ACCESS and RESP.
REQ-015 memEn, memWe  output  1 each  single-port SRAM enable / write enable.
REQ-016 memAddr  output  14  word address = latched addr[15:2].
REQ-017 memWdata  output  32  latched store data.
REQ-018 memRdata  input  32  SRAM read data, valid in the last ACCESS cycle.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; requests sampled only in IDLE.
REQ-020 IDLE with any request: assert exactly one of iGnt/dGnt combinationally that cycle; latch owner, addr, we, wdata; load cnt=LATENCY-1; next state ACCESS.
REQ-021 IDLE with no request: stay IDLE, no grant, memEn=0.
REQ-022 Priority: dReq wins over iReq, except iReq wins when starve==STARVE_MAX.
REQ-023 starve: +1 on each dGnt while iReq high; cleared on iGnt or on dGnt with iReq low; saturates at STARVE_MAX.
REQ-024 ACCESS: memEn=1, memAddr/memWdata from latches, memWe=latched we, all ACCESS cycles; cnt decrements each cycle.
REQ-025 ACCESS with cnt==0: rdata<=memRdata at that edge (loads and stores); next state RESP.
REQ-026 RESP: owner's done pulse high one cycle, memEn=0; next state IDLE.
REQ-027 Per-transfer occupancy is LATENCY+2 cycles (grant, LATENCY access, response).
REQ-028 Requester seeing done may keep req high with new addr/data; treated as new request in following IDLE.
REQ-029 Request changes outside IDLE are ignored; non-owner requests wait.
REQ-030 rdata holds its value until next capture; gnt/done never both high for the same requester in one cycle.

Reset
REQ-031 reset high at posedge: state=IDLE, cnt=0, starve=0, owner=instr, latches=0, rdata=0.
REQ-032 During and after reset: all gnt/done, busy, memEn, memWe = 0; memAddr, memWdata = 0.
REQ-033 Reset during ACCESS or RESP aborts transfer: no done pulse issued; store may be partially applied.

Verification (LATENCY=2 unless noted)
REQ-034 iReq=1, iAddr=0x0040_0008 at cycle 0 -> iGnt cycle 0; memEn=1, memAddr=0x0002 cycles 1-2; iDone=1, rdata=SRAM[2] cycle 3; busy low cycle 4.
REQ-035 iReq and dReq both high cycle 0 (dWe=0, dAddr=0x10) -> dGnt cycle 0, dDone cycle 3; iGnt cycle 4, iDone cycle 7.
REQ-036 STARVE_MAX=2, iReq and dReq held high continuously -> grant order D, D, I, D, D, I.
REQ-037 Store dWe=1, dAddr=0x54, dWdata=0x0000_0007 -> memWe=1, memAddr=0x15, memWdata=7 cycles 1-2, dDone cycle 3; following load of 0x54 returns rdata=0x0000_0007.
REQ-038 reset pulsed in first ACCESS cycle -> next cycle memEn=0, busy=0, starve=0; no iDone/dDone until a new grant.
